crossing_stop_controller: RTL

Frame-level decision sequencer between the pattern recognition block and the vehicle state machine. It consumes one detection result per frame, applies a multi-frame confirm/hold/release policy, and drives a registered `stop` request, replacing the direct `crossing_detected & detection_valid` gating. An optional watchdog detects a stalled camera/detection pipeline and requests a camera config resend.

---
 rtl/crossing_ctrl_pkg.sv | 25 ++
 rtl/frame_watchdog.sv | 33 +++
 rtl/crossing_stop_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/crossing_ctrl_pkg.sv
// Shared state type and encodings for the crossing stop controller.
// Imported by the controller RTL and by its bench.
package crossing_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_STOP    = 3'd3,
    ST_RELEASE = 3'd4
  } crossing_state_t;

  localparam logic [STATE_W-1:0] STATE_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] STATE_SEARCH  = 3'd1;
  localparam logic [STATE_W-1:0] STATE_CONFIRM = 3'd2;
  localparam logic [STATE_W-1:0] STATE_STOP    = 3'd3;
  localparam logic [STATE_W-1:0] STATE_RELEASE = 3'd4;

  function automatic logic is_stopping(input crossing_state_t s);
    return (s == ST_STOP) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Counts enabled cycles since the last kick and flags a stalled frame source.
// timeout_pulse is combinational; the parent registers it.
module frame_watchdog #(
  parameter int WD_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic timeout_pulse
);

  localparam int CW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(WD_CYCLES - 1);

  logic [CW-1:0] count;
  logic          terminal;

  // A kick in the terminal cycle wins over the timeout.
  assign terminal      = enable && !kick && (count == TERMINAL);
  assign timeout_pulse = terminal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || kick || terminal) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/crossing_stop_controller.sv
// Multi-frame confirm/hold/release sequencer driving a registered stop request.
// Optional stalled-pipeline watchdog under CROSSING_WATCHDOG_EN.
module crossing_stop_controller
  import crossing_ctrl_pkg::*;
#(
  parameter int CNT_W           = 17,
  parameter int WHITE_MIN       = 1500,
  parameter int CONFIRM_FRAMES  = 3,
  parameter int MIN_HOLD_FRAMES = 30,
  parameter int RELEASE_FRAMES  = 5,
  parameter int WD_CYCLES       = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             det_valid,
  input  logic             det_crossing,
  input  logic [CNT_W-1:0] white_count,
  input  logic             override_clear,
  output logic             stop,
  output logic [2:0]       state,
  output logic             resend_cfg,
  output logic             fault
);

  localparam int POS_W  = $clog2(CONFIRM_FRAMES + 1);
  localparam int HOLD_W = $clog2(MIN_HOLD_FRAMES + 2);
  localparam int NEG_W  = $clog2(RELEASE_FRAMES + 1);

  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(CONFIRM_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD_FRAMES);
  localparam logic [NEG_W-1:0]  NEG_MAX   = NEG_W'(RELEASE_FRAMES);
  localparam logic [CNT_W-1:0]  WHITE_THR = CNT_W'(WHITE_MIN);

  crossing_state_t   state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d, pos_inc;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [NEG_W-1:0]  neg_q, neg_d, neg_inc;
  logic              stop_q;
  logic              pos_frame, neg_frame;

  // det_valid is a single-cycle strobe with no back-pressure: det_crossing and
  // white_count are sampled only in cycles where it is high, and every strobe
  // is consumed (there is no ready).
  assign pos_frame = det_valid && det_crossing && (white_count >= WHITE_THR);
  assign neg_frame = det_valid && !pos_frame;

  assign pos_inc  = (pos_q  == POS_MAX)  ? pos_q  : pos_q  + 1'b1;
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  assign neg_inc  = (neg_q  == NEG_MAX)  ? neg_q  : neg_q  + 1'b1;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hold_d  = hold_q;
    neg_d   = neg_q;
    if (!enable) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      hold_d  = '0;
      neg_d   = '0;
    end else if (override_clear && is_stopping(state_q)) begin
      state_d = ST_SEARCH;
      pos_d   = '0;
      hold_d  = '0;
      neg_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (pos_frame) begin
            pos_d = POS_W'(1);
            if (CONFIRM_FRAMES == 1) begin
              state_d = ST_STOP;
              hold_d  = '0;
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (pos_frame) begin
            pos_d = pos_inc;
            if (pos_inc == POS_MAX) begin
              state_d = ST_STOP;
              hold_d  = '0;
            end
          end else if (neg_frame) begin
            state_d = ST_SEARCH;
            pos_d   = '0;
          end
        end
        ST_STOP: begin
          if (det_valid) begin
            hold_d = hold_inc;
            // Release is only considered once the minimum hold has elapsed.
            if (neg_frame && (hold_q >= HOLD_MAX)) begin
              if (RELEASE_FRAMES == 1) begin
                state_d = ST_SEARCH;
                pos_d   = '0;
                hold_d  = '0;
                neg_d   = '0;
              end else begin
                state_d = ST_RELEASE;
                neg_d   = NEG_W'(1);
              end
            end
          end
        end
        ST_RELEASE: begin
          if (neg_frame) begin
            if (neg_inc == NEG_MAX) begin
              state_d = ST_SEARCH;
              pos_d   = '0;
              hold_d  = '0;
              neg_d   = '0;
            end else begin
              neg_d = neg_inc;
            end
          end else if (pos_frame) begin
            state_d = ST_STOP;
            neg_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pos_d   = '0;
          hold_d  = '0;
          neg_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      hold_q  <= '0;
      neg_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hold_q  <= hold_d;
      neg_q   <= neg_d;
      // Masking with override_clear keeps stop low during the one-cycle
      // excursion into STOP that a held override can still produce.
      stop_q  <= is_stopping(state_d) && !override_clear;
    end
  end

  assign stop  = stop_q;
  assign state = state_q;

`ifdef CROSSING_WATCHDOG_EN
  logic timeout;
  logic resend_q;
  logic fault_q;

  frame_watchdog #(
    .WD_CYCLES (WD_CYCLES)
  ) u_frame_watchdog (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .kick          (det_valid),
    .timeout_pulse (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resend_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      resend_q <= timeout;
      if (det_valid) begin
        fault_q <= 1'b0;
      end else if (timeout) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign resend_cfg = resend_q;
  assign fault      = fault_q;
`else
  assign resend_cfg = 1'b0;
  assign fault      = 1'b0;
`endif

endmodule
